// File: rtl/pc_seq_if.sv
// Front-end PC sequencer bus: advance controls from next-PC selection, fetch address and return-stack status back.
interface pc_seq_if #(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 4
);
    localparam int CW = $clog2(RAS_DEPTH) + 1;

    logic             ena;
    logic [1:0]       op;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic [CW-1:0]    ras_count;
    logic             ras_full;
    logic             ras_empty;
    logic             ras_ovf;
    logic             ras_unf;

    modport master (
        output ena, op, data_in,
        input  data_out, ras_count, ras_full, ras_empty, ras_ovf, ras_unf
    );

    modport slave (
        input  ena, op, data_in,
        output data_out, ras_count, ras_full, ras_empty, ras_ovf, ras_unf
    );
endinterface

// File: rtl/pc_seq_unit.sv
// Program-counter sequencer: hold/increment/load/call/return with a circular return-address stack.
module pc_seq_unit #(
    parameter int          WIDTH     = 32,
    parameter logic [31:0] RESET_VEC = 32'h0040_0000,
    parameter int          INC       = 4,
    parameter int          RAS_DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    pc_seq_if.slave  bus
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [WIDTH-1:0] RST_PC = WIDTH'(RESET_VEC);
    localparam logic [WIDTH-1:0] INC_W  = WIDTH'(INC);
    localparam logic [CW-1:0]    DEPTH_C = CW'(RAS_DEPTH);

    typedef enum logic [1:0] {OP_SEQ = 2'b00, OP_LOAD = 2'b01, OP_CALL = 2'b10, OP_RET = 2'b11} op_e;

    logic [WIDTH-1:0] pc, pc_nxt, seq;
    logic [WIDTH-1:0] ras [RAS_DEPTH];
    logic [PW-1:0]    sp, sp_nxt, sp_dec;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             ovf, ovf_nxt, unf, unf_nxt;
    logic             push, full, empty;

    assign seq    = pc + INC_W;
    assign sp_dec = sp - PW'(1);
    assign full   = (cnt == DEPTH_C);
    assign empty  = (cnt == '0);

    // sp addresses the next free slot; when full it lands on the oldest entry,
    // so a push there overwrites it and pops stay LIFO over the survivors.
    always_comb begin
        pc_nxt  = pc;
        sp_nxt  = sp;
        cnt_nxt = cnt;
        ovf_nxt = ovf;
        unf_nxt = unf;
        push    = 1'b0;
        unique case (op_e'(bus.op))
            OP_SEQ:  pc_nxt = seq;
            OP_LOAD: pc_nxt = bus.data_in;
            OP_CALL: begin
                push   = 1'b1;
                pc_nxt = bus.data_in;
                sp_nxt = sp + PW'(1);
                if (full) ovf_nxt = 1'b1;
                else      cnt_nxt = cnt + CW'(1);
            end
            OP_RET: begin
                if (empty) begin
                    pc_nxt  = seq;
                    unf_nxt = 1'b1;
                end else begin
                    pc_nxt  = ras[sp_dec];
                    sp_nxt  = sp_dec;
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: pc_nxt = pc;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc  <= RST_PC;
            sp  <= '0;
            cnt <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) ras[i] <= '0;
        end else if (bus.ena) begin
            pc  <= pc_nxt;
            sp  <= sp_nxt;
            cnt <= cnt_nxt;
            ovf <= ovf_nxt;
            unf <= unf_nxt;
            if (push) ras[sp] <= seq;
        end
    end

    assign bus.data_out  = pc;
    assign bus.ras_count = cnt;
    assign bus.ras_full  = full;
    assign bus.ras_empty = empty;
    assign bus.ras_ovf   = ovf;
    assign bus.ras_unf   = unf;
endmodule

// File: tb/tb_pc_seq_unit.sv
// Directed-vector bench for pc_seq_unit: driver queues hand-computed results, a negedge monitor checks them.
module tb_pc_seq_unit;
    localparam logic [1:0] SEQ = 2'b00, LOAD = 2'b01, CALL = 2'b10, RET = 2'b11;

    typedef struct {
        string       name;
        logic [31:0] pc;
        int          cnt;
        bit          ovf;
        bit          unf;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t exp_q[$];
    exp_t e;

    pc_seq_if #(.WIDTH(32), .RAS_DEPTH(4)) bus ();

    pc_seq_unit #(
        .WIDTH(32), .RESET_VEC(32'h0040_0000), .INC(4), .RAS_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation whose cycle has arrived
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            e = exp_q.pop_front();
            vectors++;
            if (bus.data_out !== e.pc || bus.ras_count !== 3'(e.cnt) ||
                bus.ras_full !== (e.cnt == 4) || bus.ras_empty !== (e.cnt == 0) ||
                bus.ras_ovf !== e.ovf || bus.ras_unf !== e.unf) begin
                miscompares++;
                $display("FAIL %s: got pc=%h cnt=%0d full=%b empty=%b ovf=%b unf=%b, want pc=%h cnt=%0d full=%b empty=%b ovf=%b unf=%b",
                         e.name, bus.data_out, bus.ras_count, bus.ras_full, bus.ras_empty, bus.ras_ovf, bus.ras_unf,
                         e.pc, e.cnt, e.cnt == 4, e.cnt == 0, e.ovf, e.unf);
            end
        end
    end

    task automatic apply(input bit en, input logic [1:0] o, input logic [31:0] d, input string nm,
                         input logic [31:0] xpc, input int xc, input bit xo, input bit xu);
        bus.ena = en; bus.op = o; bus.data_in = d;
        exp_q.push_back('{nm, xpc, xc, xo, xu, cyc + 1});
        @(posedge clk); #1;
    endtask

    task automatic expect_now(input string nm, input logic [31:0] xpc, input int xc, input bit xo, input bit xu);
        exp_q.push_back('{nm, xpc, xc, xo, xu, cyc});
    endtask

    initial begin
        bus.ena = 1'b0; bus.op = SEQ; bus.data_in = '0;
        // 1: reset state
        #1 expect_now("reset", 32'h0040_0000, 0, 0, 0);
        @(negedge clk); #1 rst = 1'b0;

        // 2: sequential advance and stall
        apply(1, SEQ,  0,            "seq1",      32'h0040_0004, 0, 0, 0);
        apply(1, SEQ,  0,            "seq2",      32'h0040_0008, 0, 0, 0);
        apply(1, SEQ,  0,            "seq3",      32'h0040_000C, 0, 0, 0);
        apply(0, LOAD, 32'hFFFF_FFFF, "stall_ld",  32'h0040_000C, 0, 0, 0);
        apply(0, RET,  0,            "stall_ret", 32'h0040_000C, 0, 0, 0);
        apply(0, CALL, 32'h1234_5678, "stall_cal", 32'h0040_000C, 0, 0, 0);

        // 3: wrap-around
        apply(1, LOAD, 32'hFFFF_FFFC, "ld_top",    32'hFFFF_FFFC, 0, 0, 0);
        apply(1, SEQ,  0,            "seq_wrap",  32'h0000_0000, 0, 0, 0);

        // 4: nested call/return
        apply(1, LOAD, 32'h0040_0008, "ld_r",      32'h0040_0008, 0, 0, 0);
        apply(1, CALL, 32'h0000_1000, "call1",     32'h0000_1000, 1, 0, 0);
        apply(1, CALL, 32'h0000_2000, "call2",     32'h0000_2000, 2, 0, 0);
        apply(1, RET,  0,            "ret2",      32'h0000_1004, 1, 0, 0);
        apply(1, RET,  0,            "ret1",      32'h0040_000C, 0, 0, 0);

        // 5: overflow overwrites oldest, then underflow
        apply(1, CALL, 32'h0000_0100, "a1",        32'h0000_0100, 1, 0, 0);
        apply(1, CALL, 32'h0000_0200, "a2",        32'h0000_0200, 2, 0, 0);
        apply(1, CALL, 32'h0000_0300, "a3",        32'h0000_0300, 3, 0, 0);
        apply(1, CALL, 32'h0000_0400, "a4_full",   32'h0000_0400, 4, 0, 0);
        apply(1, CALL, 32'h0000_0500, "a5_ovf",    32'h0000_0500, 4, 1, 0);
        apply(0, CALL, 32'h0000_0600, "stall_ful", 32'h0000_0500, 4, 1, 0);
        apply(1, RET,  0,            "pop_a4",    32'h0000_0404, 3, 1, 0);
        apply(1, RET,  0,            "pop_a3",    32'h0000_0304, 2, 1, 0);
        apply(1, RET,  0,            "pop_a2",    32'h0000_0204, 1, 1, 0);
        apply(1, RET,  0,            "pop_a1",    32'h0000_0104, 0, 1, 0);
        apply(1, RET,  0,            "ret_unf",   32'h0000_0108, 0, 1, 1);

        // 6: async reset mid-operation, fresh start afterwards
        apply(1, CALL, 32'h0000_0700, "c7",        32'h0000_0700, 1, 1, 1);
        apply(1, CALL, 32'h0000_0800, "c8",        32'h0000_0800, 2, 1, 1);
        bus.ena = 1'b0;
        @(negedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1 expect_now("async_rst", 32'h0040_0000, 0, 0, 0);
        @(negedge clk); #1 rst = 1'b0;
        apply(1, RET,  0,            "rst_unf",   32'h0040_0004, 0, 0, 1);
        apply(1, CALL, 32'h0000_0900, "rst_call",  32'h0000_0900, 1, 0, 1);
        apply(1, RET,  0,            "rst_ret",   32'h0040_0008, 0, 0, 1);

        bus.ena = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
